id_stage_ctrl: RTL and testbench



---
 rtl/rv32_pkg.sv | 22 ++
 rtl/opcode_class.sv | 29 ++
 rtl/id_stage_ctrl.sv | 83 ++++++++
 tb/tb_id_stage_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 opcodes, immediate-format selects and decode-stage state encoding.
package rv32_pkg;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [1:0] {ID_EMPTY, ID_FULL, ID_STALL} id_state_e;
endpackage

// File: rtl/opcode_class.sv
// opcode_class: maps a 7-bit opcode to immediate format, immediate use, legality and source-register use.
module opcode_class
  import rv32_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_pick,
  output logic       uses_imm,
  output logic       illegal,
  output logic       rs1_used,
  output logic       rs2_used
);
  always_comb begin
    imm_pick = IMM_I;
    uses_imm = 1'b1;
    illegal  = 1'b0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_LOAD, OP_OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC_MEM: ;
      OP_STORE:        begin imm_pick = IMM_S; rs2_used = 1'b1; end
      OP_LUI, OP_AUIPC: begin imm_pick = IMM_U; rs1_used = 1'b0; end
      OP_BRANCH:       begin imm_pick = IMM_B; rs2_used = 1'b1; end
      OP_JAL:          begin imm_pick = IMM_J; rs1_used = 1'b0; end
      OP_OP:           begin uses_imm = 1'b0; rs2_used = 1'b1; end
      // unrecognised opcodes read no registers, so they never create a hazard
      default:         begin uses_imm = 1'b0; illegal = 1'b1; rs1_used = 1'b0; end
    endcase
  end
endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: IF/ID pipeline register with decode, load-use hazard stall, flush and stall counter.
module id_stage_ctrl
  import rv32_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   IF_VALID,
  input  logic [31:0]            IF_INSTRUCTION,
  input  logic [31:0]            IF_PC,
  output logic                   ID_READY,
  input  logic                   FLUSH,
  input  logic                   EX_READY,
  input  logic                   EX_MEMREAD,
  input  logic [4:0]             EX_RD,
  output logic                   ID_VALID,
  output logic [31:0]            ID_INSTRUCTION,
  output logic [31:0]            ID_PC,
  output logic [2:0]             IMM_PICK,
  output logic                   USES_IMM,
  output logic                   ILLEGAL,
  output logic                   ISSUE,
  output logic [STALL_CNT_W-1:0] STALL_COUNT
);
  id_state_e state, state_nxt;
  logic [2:0] dec_pick;
  logic dec_uses, dec_ill, dec_rs1, dec_rs2;
  logic rs1_used, rs2_used, hazard, capture;

  opcode_class u_cls (
    .opcode  (IF_INSTRUCTION[6:0]),
    .imm_pick(dec_pick),
    .uses_imm(dec_uses),
    .illegal (dec_ill),
    .rs1_used(dec_rs1),
    .rs2_used(dec_rs2)
  );

  assign ID_VALID = state != ID_EMPTY;
  assign hazard   = ID_VALID && EX_MEMREAD && |EX_RD &&
                    ((rs1_used && EX_RD == ID_INSTRUCTION[19:15]) ||
                     (rs2_used && EX_RD == ID_INSTRUCTION[24:20]));
  assign ISSUE    = ID_VALID && !hazard && EX_READY && !FLUSH;
  assign ID_READY = !FLUSH && (!ID_VALID || ISSUE);
  assign capture  = IF_VALID && ID_READY;

  always_comb
    state_nxt = FLUSH   ? ID_EMPTY :
                capture ? ID_FULL  :
                ISSUE   ? ID_EMPTY :
                ID_VALID ? ID_STALL : ID_EMPTY;

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state       <= ID_EMPTY;
      STALL_COUNT <= '0;
    end else begin
      state <= state_nxt;
      if (state == ID_STALL && !(&STALL_COUNT))
        STALL_COUNT <= STALL_COUNT + 1'b1;
    end

  // decode results travel with the instruction so they stay aligned with ID_INSTRUCTION
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      ID_INSTRUCTION <= '0;
      ID_PC          <= '0;
      IMM_PICK       <= IMM_I;
      USES_IMM       <= 1'b0;
      ILLEGAL        <= 1'b0;
      rs1_used       <= 1'b0;
      rs2_used       <= 1'b0;
    end else if (capture) begin
      ID_INSTRUCTION <= IF_INSTRUCTION;
      ID_PC          <= IF_PC;
      IMM_PICK       <= dec_pick;
      USES_IMM       <= dec_uses;
      ILLEGAL        <= dec_ill;
      rs1_used       <= dec_rs1;
      rs2_used       <= dec_rs2;
    end
endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl: directed and random stimulus against a behavioural model of the decode stage.
module tb_id_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_valid, flush, ex_ready, ex_memread;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  ex_rd;
  logic        id_ready, id_valid, uses_imm, illegal, issue;
  logic [31:0] id_instr, id_pc;
  logic [2:0]  imm_pick;
  logic [15:0] stall_count;
  logic        s_ready, s_valid, s_uses, s_ill, s_issue;
  logic [31:0] s_instr, s_pc;
  logic [2:0]  s_pick, s_count;

  id_stage_ctrl #(.STALL_CNT_W(16)) dut (
    .CLK(clk), .RESET_N(rst_n), .IF_VALID(if_valid), .IF_INSTRUCTION(if_instr), .IF_PC(if_pc),
    .ID_READY(id_ready), .FLUSH(flush), .EX_READY(ex_ready), .EX_MEMREAD(ex_memread), .EX_RD(ex_rd),
    .ID_VALID(id_valid), .ID_INSTRUCTION(id_instr), .ID_PC(id_pc), .IMM_PICK(imm_pick),
    .USES_IMM(uses_imm), .ILLEGAL(illegal), .ISSUE(issue), .STALL_COUNT(stall_count)
  );

  // narrow counter copy so saturation is reachable in a few cycles
  id_stage_ctrl #(.STALL_CNT_W(3)) dut_sat (
    .CLK(clk), .RESET_N(rst_n), .IF_VALID(if_valid), .IF_INSTRUCTION(if_instr), .IF_PC(if_pc),
    .ID_READY(s_ready), .FLUSH(flush), .EX_READY(ex_ready), .EX_MEMREAD(ex_memread), .EX_RD(ex_rd),
    .ID_VALID(s_valid), .ID_INSTRUCTION(s_instr), .ID_PC(s_pc), .IMM_PICK(s_pick),
    .USES_IMM(s_uses), .ILLEGAL(s_ill), .ISSUE(s_issue), .STALL_COUNT(s_count)
  );

  int vectors = 0;
  int errors = 0;

  bit          m_valid, m_stalled;
  logic [31:0] m_instr, m_pc;
  int          m_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {imm_pick[2:0], uses_imm, illegal, rs1_used, rs2_used}
  function automatic logic [6:0] cls(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: return 7'b000_1_0_1_0;
      7'b0100011:             return 7'b001_1_0_1_1;
      7'b0110111, 7'b0010111: return 7'b010_1_0_0_0;
      7'b1100011:             return 7'b011_1_0_1_1;
      7'b1101111:             return 7'b100_1_0_0_0;
      7'b0110011:             return 7'b000_0_0_1_1;
      default:                return 7'b000_0_1_0_0;
    endcase
  endfunction

  function automatic bit m_hazard();
    logic [6:0] c;
    c = cls(m_instr[6:0]);
    return m_valid && ex_memread && ex_rd != 5'd0 &&
           ((c[1] && ex_rd == m_instr[19:15]) || (c[0] && ex_rd == m_instr[24:20]));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_stalled = 0; m_instr = '0; m_pc = '0; m_stalls = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit fl, input bit rdy,
                       input bit mr, input logic [4:0] rd);
    if_valid = v; if_instr = ins; if_pc = $urandom; flush = fl;
    ex_ready = rdy; ex_memread = mr; ex_rd = rd;
  endtask

  // one clock cycle: check everything visible now, then advance the model across the edge
  task automatic step();
    bit e_issue, e_ready;
    logic [6:0] c;
    #1;
    c = cls(m_instr[6:0]);
    e_issue = m_valid && !m_hazard() && ex_ready && !flush;
    e_ready = !flush && (!m_valid || e_issue);
    check("issue", {31'd0, issue}, {31'd0, e_issue});
    check("id_ready", {31'd0, id_ready}, {31'd0, e_ready});
    check("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    check("id_instr", id_instr, m_instr);
    check("id_pc", id_pc, m_pc);
    check("imm_pick", {29'd0, imm_pick}, {29'd0, m_instr == 0 ? 3'd0 : c[6:4]});
    check("uses_imm", {31'd0, uses_imm}, {31'd0, m_instr == 0 ? 1'b0 : c[3]});
    check("illegal", {31'd0, illegal}, {31'd0, m_instr == 0 ? 1'b0 : c[2]});
    check("stall_count", {16'd0, stall_count}, m_stalls > 65535 ? 32'd65535 : m_stalls);
    check("stall_count_sat", {29'd0, s_count}, m_stalls > 7 ? 32'd7 : m_stalls);
    @(posedge clk);
    if (m_stalled) m_stalls++;
    m_stalled = m_valid && !e_issue && !flush;
    if (flush) m_valid = 0;
    else if (if_valid && e_ready) begin m_valid = 1; m_instr = if_instr; m_pc = if_pc; end
    else if (e_issue) m_valid = 0;
    @(negedge clk);
  endtask

  logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111, 7'b0100011,
                           7'b0110111, 7'b0010111, 7'b1100011, 7'b1101111, 7'b0110011, 7'b1111111};
  logic [31:0] plan [5] = '{32'h00500093, 32'h0020A423, 32'h123452B7, 32'h00208463, 32'h010000EF};
  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LUI = 32'h123452B7;

  initial begin
    model_reset();
    drive(0, 0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, plan[i], 0, 1, 0, 0); step();
      drive(0, 0, 0, 1, 0, 0); step();
    end
    drive(1, ADD, 0, 1, 0, 0); step();
    drive(1, LUI, 0, 1, 1, 5'd1); step(); step();
    drive(1, LUI, 0, 1, 0, 5'd1); step(); step();
    foreach (plan[i]) begin
      drive(1, ADD, 0, 1, 0, 0); step();
      drive(0, 0, 0, 1, 1, i[0] ? 5'd5 : 5'd0); step();
    end
    drive(1, LUI, 0, 1, 0, 0); step();
    drive(0, 0, 0, 1, 1, 5'd1); step(); step();
    drive(1, ADD, 0, 1, 0, 0); step();
    drive(1, LUI, 0, 0, 0, 0); step(); step(); step();
    drive(1, LUI, 0, 1, 0, 0); step(); step();
    drive(1, ADD, 0, 1, 0, 0); step();
    drive(1, LUI, 1, 1, 1, 5'd1); step(); step();
    drive(1, ADD, 0, 0, 0, 0); step();
    repeat (12) step();
    // asynchronous reset in the middle of a stall
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pick", {29'd0, imm_pick}, 32'd0);
    check("rst_uses", {31'd0, uses_imm}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_count", {16'd0, stall_count}, 32'd0);
    check("rst_issue", {31'd0, issue}, 32'd0);
    check("rst_ready", {31'd0, id_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    step();
    drive(1, 32'h0000007F, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
             5'($urandom), ops[$urandom_range(0, 11)]};
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 4) < 2, 5'($urandom_range(0, 3)));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
